multi_ch_binder: RTL and testbench
==================================

Name: multi_ch_binder

Overview:
- Parametrised successor to the single-shot level-HV binder for the sparse HDC encoder datapath. Sits between the level-HV item memory and the bundler/classifier.
- Binds a frame of NUM_CH per-channel level HVs by circular right rotation. Channel c is rotated by ((c+1)*SHIFT_STEP) mod HV_DIM.
- Two modes, both using valid/ready handshakes:
  - Stream mode: emits each bound HV.
  - Bundle mode: ORs all bound HVs of the frame and emits one result.

Parameters:
- HV_DIM, 1024, hypervector width in bits; must be >= 2.
- NUM_CH, 16, channels per frame; must be >= 1.
- SHIFT_STEP, 1, per-channel rotation increment; must satisfy 1 <= SHIFT_STEP < HV_DIM.
- Derived, not overridable: CH_W = max(1, $clog2(NUM_CH)); OFF_W = max(1, $clog2(HV_DIM)).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  enable; gates start acceptance and input acceptance only.
- start  in  1  frame start request; sampled only in IDLE.
- mode  in  1  0 = stream, 1 = bundle; latched on accepted start.
- in_valid  in  1  level_hv valid.
- in_ready  out  1  binder accepts level_hv this cycle.
- level_hv  in  HV_DIM  level hypervector for the current channel.
- out_valid  out  1  out_hv/out_ch valid.
- out_ready  in  1  downstream accepts output.
- out_hv  out  HV_DIM  bound HV (stream) or OR-bundle (bundle).
- out_ch  out  CH_W  channel index of out_hv; NUM_CH-1 for a bundle result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final output handshake of a frame.

Behaviour:
- Reset and clocking:
  - Reset is nrst, asynchronous, active-low; clock is clk.
  - On reset: state = IDLE; out_hv, out_ch, out_valid, done, busy, in_ready = 0; accumulator = 0; ch counter = 0; offset = 0.
  - Reset mid-frame aborts the frame immediately. No partial output is emitted after release.
- Rotation:
  - rot[i] = level_hv[(i+offset) mod HV_DIM] (right rotate by offset).
  - For ch 0 with SHIFT_STEP = 1 this equals the legacy binder output.
- Offset tracking:
  - offset is an OFF_W-bit register, loaded with SHIFT_STEP on start.
  - On each accepted input, offset <= offset + SHIFT_STEP, minus HV_DIM if the sum is >= HV_DIM.
  - The sum is computed at OFF_W+1 bits. No multiplier.
- State IDLE:
  - in_ready = 0.
  - If start && en: latch mode, ch = 0, offset = SHIFT_STEP, accumulator = 0, go to RUN.
  - start outside IDLE is ignored.
- State RUN:
  - in_ready = en && (mode==1 || !out_valid || out_ready).
  - An input is accepted when in_valid && in_ready.
  - Stream accept: out_hv <= rot, out_ch <= ch, out_valid <= 1.
  - Bundle accept, non-last: accumulator <= accumulator | rot. out_valid stays 0.
  - Bundle accept, last channel (ch == NUM_CH-1): out_hv <= accumulator | rot, out_ch <= NUM_CH-1, out_valid <= 1.
  - Each accept increments ch. Accepting the last channel moves to FLUSH.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new output is loaded the same cycle.
  - A simultaneous handshake and new load keeps out_valid = 1 with the new data, giving full throughput of one HV per cycle.
  - out_hv and out_ch are held stable while out_valid && !out_ready.
  - The output handshake is not gated by en.
- State FLUSH:
  - in_ready = 0.
  - When out_valid && out_ready: done = 1 for that cycle only (registered, visible the following cycle), then go to IDLE.
  - A start in the same cycle as the FLUSH exit is ignored.
- en = 0 in RUN stalls input acceptance; state, counters and the output register hold, and pending output can still drain.
- NUM_CH = 1: RUN accepts one input, then FLUSH. Bundle result equals the stream result.

Test Plan:
- Stream: HV_DIM=8, NUM_CH=3, SHIFT_STEP=1; start mode 0; inputs 0x01, 0x01, 0x01 with out_ready=1 -> outputs 0x80/ch0, 0x40/ch1, 0x20/ch2 on consecutive cycles; done pulses once after the ch2 handshake; busy falls.
- Bundle: same params, mode 1, same inputs -> single output 0xE0 with out_ch=2; no out_valid before the last accept; one done pulse.
- Wrap-around: HV_DIM=8, NUM_CH=4, SHIFT_STEP=3, stream, input 0x01 each -> offsets 3, 6, 1, 4; outputs 0x20, 0x04, 0x80, 0x10.
- Backpressure: stream, out_ready=0 after the first accept -> in_ready drops; out_hv holds 0x80 for 5 cycles; releasing out_ready resumes with 0x40 and no lost or duplicated channel.
- Control corners: start pulsed in RUN ignored; en=0 for 3 cycles mid-frame -> no accepts, output unchanged; frame completes correctly after en=1.
- Reset: assert nrst low during ch1 of a 3-channel frame -> all outputs 0 immediately; after release, a new frame from start produces ch0 = 0x80 (input 0x01).

Source files
------------

// File: rtl/multi_ch_binder.sv
// Rotates each channel's level HV by (c+1)*SHIFT_STEP and emits it (stream) or ORs the frame into one HV (bundle).
// One-cycle registered output; in_ready is withheld while a stream output is stalled, and the output drains regardless of en.
module multi_ch_binder #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_CH     = 16,
    parameter int SHIFT_STEP = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OFF_W     = ($clog2(HV_DIM) > 1) ? $clog2(HV_DIM) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HV_DIM-1:0] level_hv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] out_hv,
    output logic [CH_W-1:0]   out_ch,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    logic              mode_q;
    logic [CH_W-1:0]   ch;
    logic [OFF_W-1:0]  offset;
    logic [HV_DIM-1:0] acc;
    logic [HV_DIM-1:0] rot;
    logic [OFF_W:0]    off_sum;
    logic [OFF_W-1:0]  off_next;
    logic              accept;
    logic              last;
    logic              out_hs;

    // Right rotate; a shift by HV_DIM (offset 0) yields zero, so the OR stays correct.
    assign rot = (level_hv >> offset) | (level_hv << (HV_DIM - int'(offset)));

    // Incremental modular offset: one add and one conditional subtract, no multiplier.
    assign off_sum  = {1'b0, offset} + (OFF_W+1)'(SHIFT_STEP);
    assign off_next = (off_sum >= (OFF_W+1)'(HV_DIM)) ? OFF_W'(off_sum - (OFF_W+1)'(HV_DIM))
                                                       : OFF_W'(off_sum);

    assign in_ready = (state == RUN) && en && (mode_q || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (ch == CH_W'(NUM_CH - 1));
    assign out_hs   = out_valid && out_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            ch        <= '0;
            offset    <= '0;
            acc       <= '0;
            out_hv    <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // A load below in the same cycle overrides this clear.
            if (out_hs)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && en) begin
                        mode_q <= mode;
                        ch     <= '0;
                        offset <= OFF_W'(SHIFT_STEP);
                        acc    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        offset <= off_next;
                        ch     <= ch + 1'b1;
                        if (!mode_q) begin
                            out_hv    <= rot;
                            out_ch    <= ch;
                            out_valid <= 1'b1;
                        end else if (last) begin
                            out_hv    <= acc | rot;
                            out_ch    <= CH_W'(NUM_CH - 1);
                            out_valid <= 1'b1;
                        end else begin
                            acc <= acc | rot;
                        end
                        if (last)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_hs) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ch_binder.sv
// Two binder instances (8/3/1 and 8/4/3) driven by directed and random frames against a rotation/OR reference model.
module tb_multi_ch_binder;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic [1:0] en, start, mode, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [7:0] lv  [2];
    logic [7:0] ohv [2];
    logic [1:0] och [2];

    multi_ch_binder #(.HV_DIM(8), .NUM_CH(3), .SHIFT_STEP(1)) u_a (
        .clk(clk), .nrst(nrst), .en(en[0]), .start(start[0]), .mode(mode[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .level_hv(lv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_hv(ohv[0]),
        .out_ch(och[0]), .busy(busy[0]), .done(done[0])
    );

    multi_ch_binder #(.HV_DIM(8), .NUM_CH(4), .SHIFT_STEP(3)) u_b (
        .clk(clk), .nrst(nrst), .en(en[1]), .start(start[1]), .mode(mode[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .level_hv(lv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_hv(ohv[1]),
        .out_ch(och[1]), .busy(busy[1]), .done(done[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    int nch [2] = '{3, 4};
    int stp [2] = '{1, 3};
    logic [7:0] obs [$];

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] rot_ref(logic [7:0] v, int sh);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[(i + sh) % 8];
        return r;
    endfunction

    // pat: 0 dense, 1 random, 2 out_ready low 5 cycles after first accept, 3 en low 3 cycles + start pulse in RUN
    task automatic frame(int d, bit m, int pat, bit ones);
        logic [7:0] hv [4];
        logic [7:0] acc, r;
        logic [7:0] qh [$];
        logic [1:0] qc [$];
        int  k = 0, cyc = 0, t_first = -1;
        bit  done_exp = 0, fin = 0, eir;
        for (int i = 0; i < 4; i++) hv[i] = ones ? 8'h01 : 8'($urandom);
        acc = 8'h00;
        en[d] = 1'b0; start[d] = 1'b1; mode[d] = m; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        @(posedge clk); #1;
        check("start_gated_by_en", busy[d], 0);
        check("done_idle", done[d], 0);
        en[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        check("busy_after_start", busy[d], 1);
        while (!fin) begin
            start[d] = 1'b0;
            case (pat)
                0: begin en[d] = 1; in_valid[d] = 1; out_ready[d] = 1; end
                1: begin
                    en[d]        = ($urandom_range(0, 4) != 0);
                    in_valid[d]  = 1'($urandom_range(0, 1));
                    out_ready[d] = ($urandom_range(0, 2) != 0);
                    start[d]     = (k < nch[d]) && ($urandom_range(0, 5) == 0);
                    mode[d]      = 1'($urandom_range(0, 1));
                end
                2: begin
                    en[d] = 1; in_valid[d] = 1;
                    out_ready[d] = !(t_first >= 0 && cyc > t_first && cyc <= t_first + 5);
                end
                default: begin
                    en[d] = !(t_first >= 0 && cyc > t_first && cyc <= t_first + 3);
                    in_valid[d] = 1; out_ready[d] = 1;
                    start[d] = (k < nch[d]) && (cyc == 1);
                end
            endcase
            lv[d] = (k < nch[d]) ? hv[k] : 8'h00;
            @(negedge clk);
            check("done", done[d], done_exp);
            check("busy", busy[d], !done_exp);
            if (done_exp) fin = 1;
            done_exp = 0;
            check("out_valid", out_valid[d], qh.size() != 0);
            if (qh.size() != 0) begin
                check("out_hv", ohv[d], qh[0]);
                check("out_ch", och[d], qc[0]);
            end
            eir = en[d] && (k < nch[d]) && (m || qh.size() == 0 || out_ready[d]);
            check("in_ready", in_ready[d], eir);
            if (out_valid[d] && out_ready[d] && qh.size() != 0) begin
                obs.push_back(ohv[d]);
                void'(qh.pop_front());
                void'(qc.pop_front());
                if (qh.size() == 0 && k == nch[d]) done_exp = 1;
            end
            if (in_valid[d] && eir) begin
                r = rot_ref(hv[k], ((k + 1) * stp[d]) % 8);
                if (t_first < 0) t_first = cyc;
                if (!m) begin
                    qh.push_back(r); qc.push_back(2'(k));
                end else begin
                    acc = acc | r;
                    if (k == nch[d] - 1) begin qh.push_back(acc); qc.push_back(2'(nch[d] - 1)); end
                end
                k++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc >= 400) fin = 1;
        end
        check("frame_within_budget", cyc < 400, 1);
        en[d] = 1'b0; start[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    endtask

    initial begin
        en = '0; start = '0; mode = '0; in_valid = '0; out_ready = '0;
        lv[0] = 8'h00; lv[1] = 8'h00;
        nrst = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_out_valid", out_valid[d], 0);
            check("rst_out_hv", ohv[d], 0);
            check("rst_out_ch", och[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_in_ready", in_ready[d], 0);
        end
        nrst = 1'b1;
        @(posedge clk); #1;

        obs.delete(); frame(0, 0, 0, 1);
        check("stream_count", obs.size(), 3);
        check("stream_o0", obs[0], 8'h80);
        check("stream_o1", obs[1], 8'h40);
        check("stream_o2", obs[2], 8'h20);

        obs.delete(); frame(0, 1, 0, 1);
        check("bundle_count", obs.size(), 1);
        check("bundle_o", obs[0], 8'hE0);

        obs.delete(); frame(1, 0, 0, 1);
        check("wrap_count", obs.size(), 4);
        check("wrap_o0", obs[0], 8'h20);
        check("wrap_o1", obs[1], 8'h04);
        check("wrap_o2", obs[2], 8'h80);
        check("wrap_o3", obs[3], 8'h10);

        obs.delete(); frame(0, 0, 2, 1);
        check("bp_count", obs.size(), 3);
        check("bp_o1", obs[1], 8'h40);

        obs.delete(); frame(0, 0, 3, 1);
        check("stall_count", obs.size(), 3);
        check("stall_o2", obs[2], 8'h20);

        // Reset while ch1 output is pending in a 3-channel stream frame.
        en[0] = 1; mode[0] = 0; start[0] = 1;
        @(posedge clk); #1;
        start[0] = 0; in_valid[0] = 1; lv[0] = 8'h01; out_ready[0] = 0;
        @(posedge clk); #1;
        out_ready[0] = 1;
        @(posedge clk); #1;
        check("pre_rst_ch1", och[0], 1);
        nrst = 1'b0;
        #1;
        check("arst_out_valid", out_valid[0], 0);
        check("arst_out_hv", ohv[0], 0);
        check("arst_out_ch", och[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_in_ready", in_ready[0], 0);
        check("arst_done", done[0], 0);
        in_valid[0] = 0; out_ready[0] = 0; en[0] = 0;
        #2 nrst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", busy[0], 0);
        check("post_rst_no_output", out_valid[0], 0);
        obs.delete(); frame(0, 0, 0, 1);
        check("post_rst_o0", obs[0], 8'h80);

        for (int n = 0; n < 24; n++)
            frame(n % 2, 1'($urandom_range(0, 1)), 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
